// File: rtl/utlb_lookup.sv
// utlb_lookup: fully-associative micro-TLB with JTLB refill walk and fault reporting
module utlb_lookup #(
  parameter int ENTRIES = 4,
  parameter int IDXW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tlb_en,
  input  logic [31:0] tlb_vaddr,
  input  logic        tlb_refs,
  output logic        tlb_rdy,
  output logic [31:0] tlb_paddr,
  output logic        tlb_cat,
  output logic        tlb_tlbr,
  output logic        tlb_tlbi,
  output logic        tlb_tlbm,
  input  logic [7:0]  asid,
  input  logic        flush,
  output logic        jtlb_req,
  output logic [19:0] jtlb_vpn,
  output logic [7:0]  jtlb_asid,
  input  logic        jtlb_ack,
  input  logic        jtlb_hit,
  input  logic [19:0] jtlb_pfn,
  input  logic [2:0]  jtlb_c,
  input  logic        jtlb_d,
  input  logic        jtlb_v,
  input  logic        jtlb_g
);
  typedef enum logic [1:0] {IDLE, WALK, FAULT} state_t;
  state_t state, state_nx;
  logic [ENTRIES-1:0] vld;
  logic [19:0] e_vpn [ENTRIES];
  logic [19:0] e_pfn [ENTRIES];
  logic [7:0]  e_asid [ENTRIES];
  logic [2:0]  e_c [ENTRIES];
  logic        e_g [ENTRIES];
  logic        e_d [ENTRIES];
  logic [IDXW-1:0] repl_ptr;
  logic drop, code_r;
  logic hit, h_d;
  logic [19:0] h_pfn;
  logic [2:0] h_c;
  logic miss, fill, ihit, fhit;
  // CAM match; fills never duplicate a VPN/ASID pair so the OR-merge sees at most one entry
  always_comb begin
    hit = 1'b0;
    h_d = 1'b0;
    h_pfn = '0;
    h_c = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (vld[i] && e_vpn[i] == tlb_vaddr[31:12] && (e_g[i] || e_asid[i] == asid)) begin
        hit = 1'b1;
        h_d = h_d | e_d[i];
        h_pfn = h_pfn | e_pfn[i];
        h_c = h_c | e_c[i];
      end
  end
  // next state and lookup results; a flush in the ack cycle drops the walk like an earlier one
  always_comb begin
    miss = state == IDLE && tlb_en && !hit;
    fill = state == WALK && jtlb_ack && !drop && !flush && jtlb_hit && jtlb_v;
    state_nx = state == IDLE ? (miss ? WALK : IDLE) :
               state == WALK ? (!jtlb_ack ? WALK : (drop || flush || fill) ? IDLE : FAULT) : IDLE;
    ihit = state == IDLE && tlb_en && hit;
    fhit = state == FAULT && tlb_en && tlb_vaddr[31:12] == jtlb_vpn;
    tlb_rdy = ihit || fhit;
    tlb_paddr = ihit ? {h_pfn, tlb_vaddr[11:0]} : '0;
    tlb_cat = ihit && h_c == 3'd3;
    tlb_tlbm = ihit && tlb_refs && !h_d;
    tlb_tlbr = fhit && code_r;
    tlb_tlbi = fhit && !code_r;
    jtlb_req = state == WALK;
  end
  // control state, valid bits, replacement pointer and the walk request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vld <= '0;
      repl_ptr <= '0;
      jtlb_vpn <= '0;
      jtlb_asid <= '0;
      drop <= 1'b0;
      code_r <= 1'b0;
    end else begin
      state <= state_nx;
      vld <= flush ? '0 : fill ? vld | (ENTRIES'(1) << repl_ptr) : vld;
      if (fill) repl_ptr <= repl_ptr + IDXW'(1);
      if (miss) begin
        jtlb_vpn <= tlb_vaddr[31:12];
        jtlb_asid <= asid;
      end
      drop <= state == WALK && !jtlb_ack && (drop || flush);
      if (state == WALK && jtlb_ack) code_r <= !jtlb_hit;
    end
  end
  // entry payload; only meaningful where vld is set, so no reset needed
  always_ff @(posedge clk) begin
    if (fill) begin
      e_vpn[repl_ptr] <= jtlb_vpn;
      e_asid[repl_ptr] <= jtlb_asid;
      e_g[repl_ptr] <= jtlb_g;
      e_pfn[repl_ptr] <= jtlb_pfn;
      e_c[repl_ptr] <= jtlb_c;
      e_d[repl_ptr] <= jtlb_d;
    end
  end
endmodule

// File: doc/utlb_lookup.md
Name: utlb_lookup

Overview:
- Micro-TLB that sits directly downstream of the MMU on its TLB port.
- It answers mapped-segment translations (kuseg/kseg2/kseg3) from a small fully-associative cache of 4 KB page translations.
- On a miss it runs a request/acknowledge walk to the shared joint TLB (JTLB), then refills.
- It returns paddr, cacheability and TLB refill/invalid/modify exception flags, qualified by tlb_rdy.

Parameters:
- ENTRIES, 4, number of micro-TLB entries; power of two, 2..8.
- IDXW, 2, log2(ENTRIES); width of the replacement pointer.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- tlb_en  in  1  lookup request from MMU (mapped segment, ERL=0)
- tlb_vaddr  in  32  virtual address
- tlb_refs  in  1  access is a store (byte write-enable nonzero)
- tlb_rdy  out  1  result valid this cycle
- tlb_paddr  out  32  physical address {pfn, vaddr[11:0]}
- tlb_cat  out  1  cacheable (C field == 3)
- tlb_tlbr  out  1  TLB refill exception
- tlb_tlbi  out  1  TLB invalid exception
- tlb_tlbm  out  1  TLB modified exception
- asid  in  8  current EntryHi.ASID
- flush  in  1  invalidate all entries (TLBWI/TLBWR/TLBP side effect, ASID write)
- jtlb_req  out  1  walk request
- jtlb_vpn  out  20  requested VPN (registered)
- jtlb_asid  out  8  requested ASID (registered)
- jtlb_ack  in  1  walk response valid, one-cycle pulse
- jtlb_hit  in  1  JTLB matched the VPN/ASID
- jtlb_pfn  in  20  PFN of the selected even/odd page
- jtlb_c  in  3  cache attribute
- jtlb_d  in  1  dirty (writable)
- jtlb_v  in  1  valid
- jtlb_g  in  1  global

Behaviour:
- Entry fields: vld, vpn[19:0], asid[7:0], g, pfn[19:0], c[2:0], d. Page size fixed at 4 KB; even/odd selection is done by the JTLB.
- Hit: some entry has vld && vpn==tlb_vaddr[31:12] && (g || asid match). At most one entry can hit, because a fill never duplicates a VPN/ASID pair.
- Reset: all vld=0, repl_ptr=0, state IDLE, jtlb_req=0, jtlb_vpn/jtlb_asid=0. All tlb_* outputs are 0 whenever tlb_en=0.
- States: IDLE, WALK, FAULT.
- IDLE, tlb_en && hit:
  - same cycle, combinational: tlb_rdy=1; tlb_paddr={pfn, vaddr[11:0]}; tlb_cat=(c==3).
  - tlb_tlbm=tlb_refs && !d. The paddr is still driven; the MMU suppresses the bus.
  - Zero-cycle latency; no state change.
- IDLE, tlb_en && !hit: tlb_rdy=0. Register vaddr[31:12] and asid into jtlb_vpn/jtlb_asid. Next state WALK.
- WALK:
  - jtlb_req=1 until jtlb_ack; jtlb_vpn/jtlb_asid held stable.
  - On ack with jtlb_hit && jtlb_v and no drop pending: write entry[repl_ptr] (vld=1), repl_ptr+=1 (wraps modulo ENTRIES), next IDLE. The retried lookup hits the following cycle, giving a miss latency of ack cycle + 1.
  - On ack with !jtlb_hit: latch code R, next FAULT. On ack with jtlb_hit && !jtlb_v: latch code I, next FAULT. Faults never fill an entry.
- FAULT, one cycle:
  - If tlb_en && tlb_vaddr[31:12]==jtlb_vpn: tlb_rdy=1 plus tlb_tlbr (code R) or tlb_tlbi (code I); tlb_paddr=0; tlb_cat=0.
  - Otherwise no outputs.
  - Next state IDLE in both cases.
- flush:
  - Clears all vld in the same clock edge; repl_ptr is unchanged.
  - Flush in WALK sets a drop flag. The walk continues until ack; the result is discarded, no fill and no FAULT, then IDLE (the requester re-misses). The drop flag clears on leaving WALK.
  - Flush in IDLE concurrent with a hit: the hit is still reported that cycle.
- tlb_en deasserted during WALK: the walk is not cancelled. A valid result still fills; a fault result still goes to FAULT, where the vpn check suppresses the flags.
- A fill whose vpn/asid already exists is impossible (it would have hit). repl_ptr overwrites the oldest slot.
- rst during WALK: immediate return to IDLE, jtlb_req=0; the JTLB must tolerate an abandoned request.
- jtlb_ack outside WALK is ignored.

Test Plan:
- Reset, then tlb_en=1 with vaddr 0x0040_1234 and asid 0x05 -> jtlb_req=1 with jtlb_vpn=0x00401. Ack with hit, v, pfn=0x1F000, c=3, d=1 -> the next cycle gives tlb_rdy=1, paddr=0x1F00_0234, cat=1.
- Repeat 0x0040_1ABC -> rdy in the same cycle, paddr=0x1F00_0ABC, jtlb_req stays 0. Change asid to 0x06 with g=0 -> miss and walk. With g=1 -> hit.
- Store to a page filled with d=0 (refs=1) -> rdy=1, tlbm=1, tlbr=tlbi=0, no walk.
- Miss on 0x7FFF_F000, ack with jtlb_hit=0 -> next cycle rdy=1, tlbr=1, no fill. Ack with hit=1, v=0 -> tlbi=1. A subsequent access misses again.
- Fill 5 distinct VPNs with ENTRIES=4 -> the 5th overwrites slot 0; the first VPN re-walks, the others hit.
- Assert flush 2 cycles into a walk, then ack a valid result -> no fill, IDLE, same address re-walks. Flush in IDLE -> every entry misses afterwards.
